// File: rtl/am_nco_modulator.sv
// Dual-NCO AM source: message and carrier phase accumulators index a shared-format
// cosine ROM, then a 4-stage pipeline applies depth and mode (AM / DSB-SC / CW / OFF).

module am_nco_cos_lut #(
  parameter int LUT_AW = 10,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] idx_i,
  output logic [DW-1:0]     cos_o
);
  localparam int N   = 2**LUT_AW;
  localparam int AMP = 2**(DW-1) - 1;

  // Rounded half away from zero, so the table is symmetric and never hits -2^(DW-1).
  function automatic logic [DW-1:0] cos_val(input int k);
    real r;
    r = real'(AMP) * $cos(6.283185307179586 * real'(k) / real'(N));
    if (r >= 0.0) cos_val = DW'($rtoi(r + 0.5));
    else          cos_val = DW'(-$rtoi(0.5 - r));
  endfunction

  logic [DW-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic [DW-1:0] V = cos_val(k);
    assign rom[k] = V;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cos_o <= '0;
    else        cos_o <= rom[idx_i];
endmodule

module am_nco_modulator #(
  parameter int              ACC_W       = 32,
  parameter int              LUT_AW      = 10,
  parameter int              DW          = 8,
  parameter logic [ACC_W-1:0] FCW_CAR_RST = 32'h051EB852,
  parameter logic [ACC_W-1:0] FCW_MSG_RST = 32'h0083126F,
  parameter logic [DW-1:0]   DEPTH_RST   = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sync_clr,
  input  logic                   cfg_load,
  input  logic [ACC_W-1:0]       fcw_car,
  input  logic [ACC_W-1:0]       fcw_msg,
  input  logic [DW-1:0]          depth,
  input  logic [1:0]             mode,
  output logic                   cfg_pending,
  output logic                   out_valid,
  output logic signed [2*DW-1:0] AM_mod
);
  localparam int NCO    = 2;
  localparam int MSG    = 0;
  localparam int CAR    = 1;
  localparam int STAGES = 4;

  localparam logic [1:0] M_AM  = 2'd0;
  localparam logic [1:0] M_DSB = 2'd1;
  localparam logic [1:0] M_CW  = 2'd2;

  typedef struct packed {
    logic [ACC_W-1:0] fcw_car;
    logic [ACC_W-1:0] fcw_msg;
    logic [DW-1:0]    depth;
    logic [1:0]       mode;
  } cfg_t;

  localparam cfg_t CFG_RST = '{fcw_car: FCW_CAR_RST, fcw_msg: FCW_MSG_RST,
                               depth: DEPTH_RST, mode: M_AM};

  cfg_t sh_q, act_q;
  logic pend_q, pend_d, apply, msg_wrap, msg_carry;
  logic [NCO-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] msg_sum, car_sum;

  assign {msg_carry, msg_sum} = {1'b0, acc_q[MSG]} + {1'b0, act_q.fcw_msg};
  assign car_sum  = acc_q[CAR] + act_q.fcw_car;
  assign msg_wrap = en & msg_carry;

  // An idle NCO has no phase to glitch, so config may land on any en=0 cycle.
  assign apply  = ~en | (pend_q & msg_wrap);
  assign pend_d = cfg_load | (pend_q & ~apply);

  always_comb begin
    acc_d = acc_q;
    if (sync_clr) acc_d = '0;
    else if (en) begin
      acc_d[MSG] = msg_sum;
      acc_d[CAR] = car_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= CFG_RST;
      act_q  <= CFG_RST;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
      if (cfg_load) sh_q  <= {fcw_car, fcw_msg, depth, mode};
      if (apply)    act_q <= sh_q;
    end
  end

  // S1: registered ROM read per NCO lane
  logic [NCO-1:0][DW-1:0] cos_s1;

  for (genvar i = 0; i < NCO; i++) begin : g_lane
    am_nco_cos_lut #(.LUT_AW(LUT_AW), .DW(DW)) u_lut (
      .clk   (clk),
      .rst_n (rst_n),
      .idx_i (acc_q[i][ACC_W-1 -: LUT_AW]),
      .cos_o (cos_s1[i])
    );
  end

  logic [STAGES:1]          vld_pipe_q;
  logic signed [2*DW:0]     p_q, p_d;
  logic [DW:0]              p_sh, env_q, env_d;
  logic signed [DW-1:0]     msg_s2_q, msg_s3_q, car_s2_q, car_s3_q;
  logic signed [2*DW-1:0]   am_q, am_d, prod_am, prod_dsb, prod_cw;

  // depth is unsigned: zero-extend before the signed multiply
  assign p_d   = (2*DW+1)'($signed(cos_s1[MSG])) * $signed({{(DW+1){1'b0}}, act_q.depth});
  // floor(p / 2^DW) lies in [-(2^(DW-1)-1), 2^(DW-1)-2], so DW+1 bits hold env exactly
  assign p_sh  = (DW+1)'(p_q >>> DW);
  assign env_d = p_sh + (DW+1)'(2**(DW-1));

  assign prod_am  = (2*DW)'($signed({1'b0, env_q})) * (2*DW)'(car_s3_q);
  assign prod_dsb = ((2*DW)'(msg_s3_q) * (2*DW)'(car_s3_q)) <<< 1;
  assign prod_cw  = (2*DW)'(car_s3_q) <<< (DW-1);

  always_comb begin
    am_d = '0;
    if (vld_pipe_q[STAGES-1]) begin
      case (act_q.mode)
        M_AM:    am_d = prod_am;
        M_DSB:   am_d = prod_dsb;
        M_CW:    am_d = prod_cw;
        default: am_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      p_q        <= '0;
      msg_s2_q   <= '0;
      car_s2_q   <= '0;
      env_q      <= '0;
      msg_s3_q   <= '0;
      car_s3_q   <= '0;
      am_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], en};
      p_q        <= p_d;
      msg_s2_q   <= $signed(cos_s1[MSG]);
      car_s2_q   <= $signed(cos_s1[CAR]);
      env_q      <= env_d;
      msg_s3_q   <= msg_s2_q;
      car_s3_q   <= car_s2_q;
      am_q       <= am_d;
    end
  end

  assign cfg_pending = pend_q;
  assign out_valid   = vld_pipe_q[STAGES];
  assign AM_mod      = am_q;
endmodule

// File: tb/tb_am_nco_modulator.sv
// Scoreboard bench for am_nco_modulator: a cycle-level behavioural model predicts each
// sample from the cosine formula and config rules; a negedge monitor pops and compares.

module tb_am_nco_modulator;
  localparam logic [31:0] FC_RST = 32'h051EB852;
  localparam logic [31:0] FM_RST = 32'h0083126F;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, sync_clr = 1'b0, cfg_load = 1'b0;
  logic [31:0] fcw_car = '0, fcw_msg = '0;
  logic [7:0]  depth = '0;
  logic [1:0]  mode = '0;
  logic        cfg_pending, out_valid;
  logic signed [15:0] AM_mod;

  am_nco_modulator dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_load(cfg_load),
    .fcw_car(fcw_car), .fcw_msg(fcw_msg), .depth(depth), .mode(mode),
    .cfg_pending(cfg_pending), .out_valid(out_valid), .AM_mod(AM_mod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit en; int msg; int car; int d; } hist_t;
  typedef struct { int cyc; int val; } exp_t;

  int lut [1024];
  hist_t hq[$];
  exp_t  sbq[$];

  logic [31:0] m_acc_m, m_acc_c, a_fc, a_fm, s_fc, s_fm;
  logic [7:0]  a_d, s_d;
  logic [1:0]  a_m, s_m;
  bit          m_pend;

  function automatic int cosv(input int k);
    real r;
    r = 127.0 * $cos(2.0 * $acos(-1.0) * real'(k) / 1024.0);
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic int sample(input hist_t h, input int d, input logic [1:0] m);
    int p, env;
    p   = h.msg * d;
    env = 128 + $rtoi($floor(real'(p) / 256.0));
    case (m)
      2'd0:    return env * h.car;
      2'd1:    return 2 * h.msg * h.car;
      2'd2:    return 128 * h.car;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_wrap(input bit e);
    return e && ((longint'(m_acc_m) + longint'(a_fm)) > 64'h0FFFF_FFFF);
  endfunction

  task automatic model_reset();
    m_acc_m = '0; m_acc_c = '0;
    a_fc = FC_RST; a_fm = FM_RST; a_d = 8'hFF; a_m = 2'd0;
    s_fc = FC_RST; s_fm = FM_RST; s_d = 8'hFF; s_m = 2'd0;
    m_pend = 1'b0;
    hq.delete();
    sbq.delete();
  endtask

  // One clock: called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit e, input bit sc, input bit ld, input logic [31:0] fc,
                      input logic [31:0] fm, input logic [7:0] d, input logic [1:0] m);
    hist_t h, cur;
    bit wr, ap;
    logic [31:0] o_fc, o_fm;
    logic [7:0]  o_d;
    logic [1:0]  o_m;
    chk("cfg_pending", int'(cfg_pending), int'(m_pend));
    en = e; sync_clr = sc; cfg_load = ld;
    fcw_car = fc; fcw_msg = fm; depth = d; mode = m;

    cur.en = e; cur.msg = lut[m_acc_m[31:22]]; cur.car = lut[m_acc_c[31:22]]; cur.d = int'(a_d);
    hq.push_back(cur);
    if (hq.size() == 4) begin
      h = hq.pop_front();
      // depth seen one cycle after the phase sample, mode three cycles after
      if (h.en) sbq.push_back('{cyc: cyc + 1, val: sample(h, hq[0].d, a_m)});
    end

    wr = model_wrap(e);
    ap = !e || (m_pend && wr);
    o_fc = s_fc; o_fm = s_fm; o_d = s_d; o_m = s_m;
    if (sc) begin
      m_acc_m = '0; m_acc_c = '0;
    end else if (e) begin
      m_acc_m = m_acc_m + a_fm;
      m_acc_c = m_acc_c + a_fc;
    end
    if (ap) begin a_fc = o_fc; a_fm = o_fm; a_d = o_d; a_m = o_m; end
    if (ld) begin s_fc = fc; s_fm = fm; s_d = d; s_m = m; end
    m_pend = ld || (m_pend && !ap);

    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++)
      step(e, 1'b0, 1'b0, $urandom, $urandom, 8'($urandom), 2'($urandom));
  endtask

  task automatic load(input bit e, input logic [31:0] fc, input logic [31:0] fm,
                      input logic [7:0] d, input logic [1:0] m);
    step(e, 1'b0, 1'b1, fc, fm, d, m);
  endtask

  task automatic clr(input bit e);
    step(e, 1'b1, 1'b0, $urandom, $urandom, 8'($urandom), 2'($urandom));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    en = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
    #1;
    chk("rst_AM_mod", int'(AM_mod), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cfg_pending", int'(cfg_pending), 0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_sample", int'(AM_mod), -1);
        end else begin
          x = sbq.pop_front();
          chk("sample_cycle", cyc, x.cyc);
          chk("AM_mod", int'(AM_mod), x.val);
        end
      end else begin
        chk("idle_AM_mod", int'(AM_mod), 0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          x = sbq.pop_front();
          chk("missing_sample", 0, x.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    for (int k = 0; k < 1024; k++) lut[k] = cosv(k);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_AM_mod", int'(AM_mod), 0);
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_cfg_pending", int'(cfg_pending), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // defaults: first sample at acc=0 is 254*127
    run(20, 1'b1);

    // CW queued while running, lands at the next message wrap
    load(1'b1, FC_RST, FM_RST, 8'hFF, 2'd2);
    run(560, 1'b1);
    clr(1'b1);
    run(20, 1'b1);

    // DSB-SC loaded while idle applies next cycle
    load(1'b0, FC_RST, 32'h1000_0000, 8'hFF, 2'd1);
    clr(1'b0);
    run(40, 1'b1);

    load(1'b1, FC_RST, 32'h1000_0000, 8'hFF, 2'd3);
    run(40, 1'b1);

    load(1'b1, 32'h0800_0000, 32'h1000_0000, 8'h00, 2'd0);
    run(60, 1'b1);

    // second strobe on the wrap cycle itself
    load(1'b1, FC_RST, 32'h1000_0000, 8'h40, 2'd2);
    guard = 0;
    while (!model_wrap(1'b1) && guard < 100) begin
      run(1, 1'b1);
      guard++;
    end
    load(1'b1, 32'h0300_0000, 32'h0C00_0000, 8'h80, 2'd1);
    run(40, 1'b1);

    // en=0 mid-stream, config load while idle
    run(10, 1'b0);
    load(1'b0, 32'h0123_4567, 32'h0800_0000, 8'hA5, 2'd0);
    run(5, 1'b0);
    run(20, 1'b1);

    // async reset mid-run restores the power-on config
    load(1'b1, 32'h0700_0000, 32'h2000_0000, 8'h11, 2'd2);
    async_reset();
    run(30, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 500) async_reset();
      step(($urandom % 10) != 0, ($urandom % 50) == 0, ($urandom % 15) == 0,
           $urandom, 32'h0400_0000 + ($urandom % 32'h3C00_0000),
           8'($urandom), 2'($urandom));
    end

    run(8, 1'b0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
